angle_correction_seq: RTL and testbench

Parametrised successor to the servo angle-correction stage in the OV5640 tracking path. It combines a source angle, a target angle and a camera-derived horizontal offset into one servo setpoint. Unlike the previous stage, the math is signed, the result is clamped to a legal servo range, and the block has a start/busy/done handshake. The result is given in binary and as a full 8-bit-per-digit ASCII string with a configurable digit count, for the UART/OSD path.

---
 rtl/angle_correction_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_angle_correction_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/angle_correction_seq.sv
`default_nettype none
// ============================================================================
// Module   : angle_correction_seq
// Purpose  : Signed servo angle correction from source/target angles and the
//            object's horizontal span. The result is clamped to a legal servo
//            range and converted to fixed-width ASCII decimal by repeated
//            subtraction. Uses a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module angle_correction_seq #(
  parameter int ANG_W    = 12,
  parameter int X_W      = 9,
  parameter int DIGITS   = 4,
  parameter int CENTER   = 1500,
  parameter int DEADBAND = 30,
  parameter int GAIN     = 75,
  parameter int ANG_MIN  = 500,
  parameter int ANG_MAX  = 2500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ANG_W-1:0]      source_angle,
  input  logic [ANG_W-1:0]      target_angle,
  input  logic [X_W-1:0]        x_left,
  input  logic [X_W-1:0]        x_right,
  input  logic                  left_or_right,
  output logic                  busy,
  output logic                  done,
  output logic [ANG_W-1:0]      corrected_bin,
  output logic [8*DIGITS-1:0]   corrected_ascii,
  output logic                  saturated
);

  // Internal signed width leaves headroom for span*GAIN plus the angle terms.
  localparam int IW    = ANG_W + X_W + 8;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IDX_W-1:0]      C_IDX_TOP  = IDX_W'(DIGITS - 1);
  localparam logic signed [IW-1:0]  C_CENTER   = IW'(CENTER);
  localparam logic signed [IW-1:0]  C_DEADBAND = IW'(DEADBAND);
  localparam logic signed [IW-1:0]  C_GAIN     = IW'(GAIN);
  localparam logic signed [IW-1:0]  C_MIN      = IW'(ANG_MIN);
  localparam logic signed [IW-1:0]  C_MAX      = IW'(ANG_MAX);
  localparam logic [ANG_W-1:0]      C_MIN_U    = ANG_W'(ANG_MIN);
  localparam logic [ANG_W-1:0]      C_MAX_U    = ANG_W'(ANG_MAX);
  localparam logic [8*DIGITS-1:0]   C_ASCII0   = {DIGITS{8'h30}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_CLAMP = 3'd2,
    ST_CONV  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // 10^n evaluated at elaboration only; the hardware sees a constant table.
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

  logic [31:0] weight_tbl [DIGITS];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_weight
      assign weight_tbl[gi] = pow10(gi);
    end
  endgenerate

  state_t                 state_q, state_d;
  logic [ANG_W-1:0]       src_q, src_d;
  logic [ANG_W-1:0]       tgt_q, tgt_d;
  logic [X_W-1:0]         xl_q, xl_d;
  logic [X_W-1:0]         xr_q, xr_d;
  logic                   lr_q, lr_d;
  logic signed [IW-1:0]   diff_q, diff_d;
  logic [ANG_W-1:0]       rem_q, rem_d;
  logic [ANG_W-1:0]       bin_pend_q, bin_pend_d;
  logic                   sat_pend_q, sat_pend_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [8*DIGITS-1:0]    dig_q, dig_d;
  logic [ANG_W-1:0]       out_bin_q, out_bin_d;
  logic [8*DIGITS-1:0]    out_ascii_q, out_ascii_d;
  logic                   out_sat_q, out_sat_d;

  // Signed correction terms, all taken from the captured operands.
  logic signed [IW-1:0] src_ext, tgt_ext, xl_ext, xr_ext;
  logic signed [IW-1:0] span, off, base;
  logic [31:0]          weight;
  logic                 rem_ge_weight;

  assign src_ext = $signed({{(IW-ANG_W){1'b0}}, src_q});
  assign tgt_ext = $signed({{(IW-ANG_W){1'b0}}, tgt_q});
  assign xl_ext  = $signed({{(IW-X_W){1'b0}}, xl_q});
  assign xr_ext  = $signed({{(IW-X_W){1'b0}}, xr_q});
  assign span    = xr_ext - xl_ext;
  assign off     = (span - C_DEADBAND) * C_GAIN;
  assign base    = C_CENTER - src_ext + tgt_ext;

  assign weight        = weight_tbl[idx_q];
  assign rem_ge_weight = ({{(32-ANG_W){1'b0}}, rem_q} >= weight);

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign corrected_bin   = out_bin_q;
  assign corrected_ascii = out_ascii_q;
  assign saturated       = out_sat_q;

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    tgt_d       = tgt_q;
    xl_d        = xl_q;
    xr_d        = xr_q;
    lr_d        = lr_q;
    diff_d      = diff_q;
    rem_d       = rem_q;
    bin_pend_d  = bin_pend_q;
    sat_pend_d  = sat_pend_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    dig_d       = dig_q;
    out_bin_d   = out_bin_q;
    out_ascii_d = out_ascii_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = source_angle;
          tgt_d   = target_angle;
          xl_d    = x_left;
          xr_d    = x_right;
          lr_d    = left_or_right;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        diff_d  = lr_q ? (base + off) : (base - off);
        state_d = ST_CLAMP;
      end

      ST_CLAMP: begin
        if (diff_q < C_MIN) begin
          bin_pend_d = C_MIN_U;
          sat_pend_d = 1'b1;
        end else if (diff_q > C_MAX) begin
          bin_pend_d = C_MAX_U;
          sat_pend_d = 1'b1;
        end else begin
          bin_pend_d = diff_q[ANG_W-1:0];
          sat_pend_d = 1'b0;
        end
        rem_d   = bin_pend_d;
        idx_d   = C_IDX_TOP;
        cnt_d   = 4'd0;
        state_d = ST_CONV;
      end

      ST_CONV: begin
        if (rem_ge_weight) begin
          rem_d = rem_q - weight[ANG_W-1:0];
          cnt_d = cnt_q + 4'd1;
        end else begin
          dig_d[int'(idx_q)*8 +: 8] = 8'h30 + {4'h0, cnt_q};
          cnt_d = 4'd0;
          if (idx_q == '0) begin
            // Publish only once the last digit is known.
            out_bin_d   = bin_pend_q;
            out_sat_d   = sat_pend_q;
            out_ascii_d = dig_d;
            state_d     = ST_DONE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset shows zero result and "0000" text.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q       <= '0;
      tgt_q       <= '0;
      xl_q        <= '0;
      xr_q        <= '0;
      lr_q        <= 1'b0;
      diff_q      <= '0;
      rem_q       <= '0;
      bin_pend_q  <= '0;
      sat_pend_q  <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= 4'd0;
      dig_q       <= C_ASCII0;
      out_bin_q   <= '0;
      out_ascii_q <= C_ASCII0;
      out_sat_q   <= 1'b0;
    end else begin
      src_q       <= src_d;
      tgt_q       <= tgt_d;
      xl_q        <= xl_d;
      xr_q        <= xr_d;
      lr_q        <= lr_d;
      diff_q      <= diff_d;
      rem_q       <= rem_d;
      bin_pend_q  <= bin_pend_d;
      sat_pend_q  <= sat_pend_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      out_bin_q   <= out_bin_d;
      out_ascii_q <= out_ascii_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_angle_correction_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_angle_correction_seq
// Purpose  : Directed and randomized checks of angle_correction_seq against
//            an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_angle_correction_seq;

  localparam int ANG_W    = 12;
  localparam int X_W      = 9;
  localparam int DIGITS   = 4;
  localparam int CENTER   = 1500;
  localparam int DEADBAND = 30;
  localparam int GAIN     = 75;
  localparam int ANG_MIN  = 500;
  localparam int ANG_MAX  = 2500;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [ANG_W-1:0]    source_angle;
  logic [ANG_W-1:0]    target_angle;
  logic [X_W-1:0]      x_left;
  logic [X_W-1:0]      x_right;
  logic                left_or_right;
  logic                busy;
  logic                done;
  logic [ANG_W-1:0]    corrected_bin;
  logic [8*DIGITS-1:0] corrected_ascii;
  logic                saturated;

  int checks   = 0;
  int failures = 0;

  angle_correction_seq #(
    .ANG_W(ANG_W), .X_W(X_W), .DIGITS(DIGITS), .CENTER(CENTER),
    .DEADBAND(DEADBAND), .GAIN(GAIN), .ANG_MIN(ANG_MIN), .ANG_MAX(ANG_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .source_angle(source_angle), .target_angle(target_angle),
    .x_left(x_left), .x_right(x_right), .left_or_right(left_or_right),
    .busy(busy), .done(done), .corrected_bin(corrected_bin),
    .corrected_ascii(corrected_ascii), .saturated(saturated)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, clamp, decimal digits.
  function automatic void model(input int s, input int t, input int l, input int r,
                                input bit dir, output int v, output bit sat, output int cyc);
    int off, diff, x;
    off  = ((r - l) - DEADBAND) * GAIN;
    diff = dir ? (CENTER - s + t + off) : (CENTER - s + t - off);
    sat  = (diff < ANG_MIN) || (diff > ANG_MAX);
    v    = (diff < ANG_MIN) ? ANG_MIN : (diff > ANG_MAX) ? ANG_MAX : diff;
    cyc  = 0;
    x    = v;
    for (int i = 0; i < DIGITS; i++) begin
      cyc += (x % 10) + 1;
      x   /= 10;
    end
  endfunction

  function automatic logic [8*DIGITS-1:0] model_ascii(input int v);
    logic [8*DIGITS-1:0] a;
    int x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      a[i*8 +: 8] = 8'(8'h30 + (x % 10));
      x /= 10;
    end
    return a;
  endfunction

  task automatic scramble();
    source_angle  = ANG_W'($urandom);
    target_angle  = ANG_W'($urandom);
    x_left        = X_W'($urandom);
    x_right       = X_W'($urandom);
    left_or_right = 1'($urandom);
  endtask

  // One request; inputs scrambled after capture; optional stray start pulses.
  task automatic request(input int s, input int t, input int l, input int r,
                         input bit dir, input bit pulses, input string tag);
    int v, cyc, n, bc;
    bit sat, seen;
    model(s, t, l, r, dir, v, sat, cyc);
    @(negedge clk);
    source_angle = ANG_W'(s); target_angle = ANG_W'(t);
    x_left = X_W'(l); x_right = X_W'(r); left_or_right = dir; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; bc = 0; seen = 1'b0; n = 0;
    while (n < 400 && !seen) begin
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        scramble();
        start = pulses && (n == 3 || n == 8);
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_latency"}, 64'(n), 64'(2 + cyc));
      check({tag, "_busy_cycles"}, 64'(bc), 64'(3 + cyc));
      check({tag, "_bin"}, 64'(corrected_bin), 64'(v));
      check({tag, "_ascii"}, 64'(corrected_ascii), 64'(model_ascii(v)));
      check({tag, "_sat"}, 64'(saturated), 64'(sat));
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    check({tag, "_bin_hold"}, 64'(corrected_bin), 64'(v));
  endtask

  initial begin : main
    int idx[3];
    int nd, n, pulses_seen;
    rst = 1'b1; start = 1'b0;
    source_angle = '0; target_angle = '0; x_left = '0; x_right = '0; left_or_right = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_bin", 64'(corrected_bin), 64'd0);
    check("reset_ascii", 64'(corrected_ascii), 64'(32'h30303030));
    check("reset_sat", 64'(saturated), 64'd0);
    rst = 1'b0;

    // Directed cases from the arithmetic rules.
    request(1500, 1500, 100, 130, 1'b0, 1'b0, "neutral");
    check("neutral_ascii_lit", 64'(corrected_ascii), 64'(32'h31353030));
    request(1500, 1500, 100, 140, 1'b0, 1'b0, "sub");
    check("sub_ascii_lit", 64'(corrected_ascii), 64'(32'h30373530));
    request(1500, 1500, 100, 140, 1'b1, 1'b0, "add");
    request(1500, 1500, 100, 200, 1'b1, 1'b0, "clamp_hi");
    request(1500, 1500, 100, 200, 1'b0, 1'b0, "clamp_lo");
    request(1500, 1500, 130, 100, 1'b0, 1'b0, "neg_span");
    request(1500, 1500, 100, 140, 1'b1, 1'b1, "stray_start");

    // Start held high: results back to back every 4+S cycles (neutral S=10).
    @(negedge clk);
    source_angle = 12'd1500; target_angle = 12'd1500;
    x_left = 9'd100; x_right = 9'd130; left_or_right = 1'b0; start = 1'b1;
    nd = 0; n = 0;
    while (nd < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        idx[nd] = n;
        nd++;
        check("b2b_bin", 64'(corrected_bin), 64'd1500);
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(nd), 64'd3);
    if (nd == 3) begin
      check("b2b_gap1", 64'(idx[1] - idx[0]), 64'd14);
      check("b2b_gap2", 64'(idx[2] - idx[1]), 64'd14);
    end
    @(negedge clk);
    check("b2b_idle", 64'(busy), 64'd0);

    // Reset during conversion of the 2250 case.
    @(negedge clk);
    source_angle = 12'd1500; target_angle = 12'd1500;
    x_left = 9'd100; x_right = 9'd140; left_or_right = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bin", 64'(corrected_bin), 64'd0);
    check("rst_ascii", 64'(corrected_ascii), 64'(32'h30303030));
    check("rst_sat", 64'(saturated), 64'd0);
    rst = 1'b0;
    pulses_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) pulses_seen++;
    end
    check("rst_no_done", 64'(pulses_seen), 64'd0);
    request(1500, 1500, 100, 130, 1'b0, 1'b0, "post_rst");

    // Randomized requests against the model.
    for (int i = 0; i < 16; i++) begin
      request(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
              1'($urandom), 1'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
